// File: rtl/hex8_scan_pkg.sv
// Shared constants and types for the 8-digit hex display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
// Every digit code leaves bit 7 (dp) set; the scanner clears it per digit.

package hex8_scan_pkg;

   // Blank word: all segments off, no digit selected.
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEL_NONE  = 8'h00;

   // Hex digit glyphs, dp off.
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   // Per-frame copy of the display inputs; held for all 8 digits of a frame.
   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  digit_en;
   } snap_t;

   // Word handed to the 74HC595 chain: segments in the upper byte.
   typedef struct packed {
      logic [7:0] seg;
      logic [7:0] sel;
   } word_t;

   localparam word_t WORD_BLANK = '{seg: SEG_BLANK, sel: SEL_NONE};

   // One-hot, active-high digit select for digit idx.
   function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

endpackage

// File: rtl/hex8_scan_seg7.sv
// Nibble to 7-segment glyph decoder (active-low, dp bit left off).
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 8  {dp,g,f,e,d,c,b,a}, active-low, dp always 1 (off)

module hex_to_seg7
   import hex8_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/hex8_scan.sv
// Time-multiplexed 8-digit hex scanner feeding a 74HC595 driver with {seg,sel} words.
// Latency: word and s_en appear 2 cycles after each divider tick; one word every DIV cycles.
// Backpressure: none; the driver must finish each 16-bit shift within DIV (>= 64) cycles.
//
// Ports:
//   clk        in  1   system clock, rising edge
//   reset_n    in  1   asynchronous active-low reset
//   disp_data  in  32  nibble k shown on digit k
//   dp         in  8   decimal point per digit, 1 = lit
//   digit_en   in  8   per-digit enable, 0 = blank
//   disp_en    in  1   global enable, 0 = blank all
//   sel        out 8   one-hot digit select, active-high
//   seg        out 8   segments {dp,g,f,e,d,c,b,a}, active-low
//   data       out 16  {seg,sel}
//   s_en       out 1   single-cycle strobe marking a new data word
//
// DIV = CLK_FREQ/SCAN_FREQ must be >= 64 in a real system so the driver
// keeps up; smaller values still scan correctly and are handy for simulation.

module hex8_scan
   import hex8_scan_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int SCAN_FREQ = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] disp_data,
   input  logic [7:0]  dp,
   input  logic [7:0]  digit_en,
   input  logic        disp_en,
   output logic [7:0]  sel,
   output logic [7:0]  seg,
   output logic [15:0] data,
   output logic        s_en
);

   localparam int DIV   = CLK_FREQ / SCAN_FREQ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   // ------------------------------------------------------------------
   // Step divider: one tick every DIV cycles
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1 (cycle after the tick): advance digit, sample disp_en,
   // and take a fresh frame snapshot when wrapping to digit 0.
   // idx resets to 7 so the very first tick wraps and captures inputs.
   // ------------------------------------------------------------------
   logic [2:0] idx;
   logic       en_q;
   logic       stg_vld;
   snap_t      snap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx     <= 3'd7;
         en_q    <= 1'b0;
         stg_vld <= 1'b0;
         snap    <= '0;
      end else begin
         stg_vld <= tick;
         if (tick) begin
            idx  <= idx + 3'd1;
            en_q <= disp_en;
            if (idx == 3'd7) begin
               snap <= '{data: disp_data, dp: dp, digit_en: digit_en};
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Digit word formation from the snapshot
   // ------------------------------------------------------------------
   logic [3:0] cur_nibble;
   logic [7:0] glyph;
   logic       blank;
   word_t      word_nxt;

   // {idx,2'b00} keeps the part-select base wide enough for bit 28.
   assign cur_nibble = snap.data[{idx, 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .nibble (cur_nibble),
      .seg    (glyph)
   );

   assign blank = !en_q || !snap.digit_en[idx];

   always_comb begin
      word_nxt = WORD_BLANK;
      if (!blank) begin
         // dp is active-low: a lit point clears bit 7 of the glyph.
         word_nxt.seg = glyph & ~{snap.dp[idx], 7'b0};
         word_nxt.sel = sel_onehot(idx);
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 (two cycles after the tick): register the word and strobe.
   // The word holds between strobes; blanked digits still strobe so the
   // shift-register chain is refreshed with the blank pattern.
   // ------------------------------------------------------------------
   word_t word_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q <= WORD_BLANK;
         s_en   <= 1'b0;
      end else begin
         s_en <= stg_vld;
         if (stg_vld) begin
            word_q <= word_nxt;
         end
      end
   end

   assign sel  = word_q.sel;
   assign seg  = word_q.seg;
   assign data = word_q;

endmodule

// File: tb/tb_hex8_scan.sv
module tb_hex8_scan;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] disp_data;
   logic [7:0]  dp;
   logic [7:0]  digit_en;
   logic        disp_en;
   logic [7:0]  sel;
   logic [7:0]  seg;
   logic [15:0] data;
   logic        s_en;

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   hex8_scan #(.CLK_FREQ(1000), .SCAN_FREQ(100)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .disp_data (disp_data),
      .dp        (dp),
      .digit_en  (digit_en),
      .disp_en   (disp_en),
      .sel       (sel),
      .seg       (seg),
      .data      (data),
      .s_en      (s_en)
   );

   // ---------------- reference model ----------------
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [15:0] pat [8] = '{16'h8001, 16'hF802, 16'h8204, 16'h9208,
                            16'h9910, 16'hB020, 16'hA440, 16'hF980};
   int          m_dig;
   logic [31:0] m_data;
   logic [7:0]  m_dp;
   logic [7:0]  m_den;

   // Expected word of the next strobe: digit number is strobe count mod 8,
   // frame inputs are captured at each digit 0.
   task automatic model_step(output logic [15:0] m);
      int nib;
      logic [7:0] s;
      if (m_dig == 0) begin
         m_data = disp_data;
         m_dp   = dp;
         m_den  = digit_en;
      end
      if (!disp_en || !m_den[m_dig]) begin
         m = 16'hFF00;
      end else begin
         nib = int'((m_data >> (4 * m_dig)) & 32'hF);
         s   = seg_tab[nib] - (m_dp[m_dig] ? 8'd128 : 8'd0);
         m   = {s, 8'(1 << m_dig)};
      end
      m_dig = (m_dig + 1) % 8;
   endtask

   // Waits (bounded) for the next strobe; returns DUT word, model word, gap in cycles.
   task automatic get_strobe(output logic [15:0] w, output logic [15:0] m, output int gap);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (s_en !== 1'b1 && gap < 40);
      if (s_en !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL strobe_timeout: no s_en within %0d cycles", gap);
      end
      w = data;
      n_checks++;
      if (data !== {seg, sel}) begin
         n_fail++;
         $display("FAIL data_concat: data=%h required {seg,sel}=%h", data, {seg, sel});
      end
      model_step(m);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] w, m;
      int gap;
      reset_n   = 1'b0;
      disp_data = 32'h1234_5678;
      dp        = 8'h00;
      digit_en  = 8'hFF;
      disp_en   = 1'b1;
      m_dig     = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (data !== 16'hFF00 || s_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: data=%h s_en=%b required FF00/0", i, data, s_en);
         end
      end
      reset_n = 1'b1;
      get_strobe(w, m, gap);
      n_checks++;
      if (gap !== 11) begin
         n_fail++;
         $display("FAIL first_strobe_latency: %0d cycles required 11", gap);
      end
      n_checks++;
      if (w !== 16'h8001) begin
         n_fail++;
         $display("FAIL first_word: %h required 8001", w);
      end
   endtask

   task automatic test_pattern();
      logic [15:0] w, m;
      int gap;
      for (int k = 1; k < 16; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== pat[k % 8] || gap !== 10) begin
            n_fail++;
            $display("FAIL pattern digit %0d: word=%h gap=%0d required %h/10", k % 8, w, gap, pat[k % 8]);
         end
      end
   endtask

   task automatic test_dp();
      logic [15:0] w, m;
      int gap;
      dp = 8'h01;
      for (int k = 0; k < 8; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== ((k == 0) ? 16'h0001 : pat[k])) begin
            n_fail++;
            $display("FAIL dp digit %0d: %h required %h", k, w, (k == 0) ? 16'h0001 : pat[k]);
         end
      end
      dp = 8'h00;
   endtask

   task automatic test_no_tear();
      logic [15:0] w, m;
      int gap;
      for (int k = 0; k < 16; k++) begin
         logic [15:0] e;
         get_strobe(w, m, gap);
         if (k == 3) disp_data = 32'hFFFF_FFFF;
         e = (k < 8) ? pat[k] : {8'h8E, 8'(1 << (k - 8))};
         n_checks++;
         if (w !== e) begin
            n_fail++;
            $display("FAIL no_tear strobe %0d: %h required %h", k, w, e);
         end
      end
      disp_data = 32'h1234_5678;
   endtask

   task automatic test_blank();
      logic [15:0] w, m;
      int gap;
      // the FFFF_FFFF -> 1234_5678 restore takes one frame; flush it with checks
      for (int k = 0; k < 8; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== m) begin
            n_fail++;
            $display("FAIL blank_flush %0d: %h required %h", k, w, m);
         end
      end
      digit_en = 8'hFE;
      for (int k = 0; k < 8; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== ((k == 0) ? 16'hFF00 : pat[k]) || gap !== 10) begin
            n_fail++;
            $display("FAIL digit_en digit %0d: word=%h gap=%0d required %h/10", k, w, gap,
                     (k == 0) ? 16'hFF00 : pat[k]);
         end
      end
      digit_en = 8'hFF;
      disp_en  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== 16'hFF00 || gap !== 10) begin
            n_fail++;
            $display("FAIL disp_en_off digit %0d: word=%h gap=%0d required FF00/10", k, w, gap);
         end
      end
      disp_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [15:0] w, m;
      int gap;
      for (int k = 0; k < 4; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== pat[k]) begin
            n_fail++;
            $display("FAIL pre_reset digit %0d: %h required %h", k, w, pat[k]);
         end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (data !== 16'h9208) begin
         n_fail++;
         $display("FAIL hold_between_strobes: %h required 9208", data);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (data !== 16'hFF00 || sel !== 8'h00 || seg !== 8'hFF || s_en !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: data=%h s_en=%b required FF00/0", data, s_en);
      end
      repeat (3) @(negedge clk);
      m_dig   = 0;
      reset_n = 1'b1;
      get_strobe(w, m, gap);
      n_checks++;
      if (w !== 16'h8001 || gap !== 11) begin
         n_fail++;
         $display("FAIL restart: word=%h gap=%0d required 8001/11", w, gap);
      end
   endtask

   task automatic test_random();
      logic [15:0] w, m;
      int gap;
      for (int k = 0; k < 64; k++) begin
         get_strobe(w, m, gap);
         n_checks++;
         if (w !== m || gap !== 10) begin
            n_fail++;
            $display("FAIL random strobe %0d: word=%h gap=%0d required %h/10", k, w, gap, m);
         end
         case ($urandom_range(0, 5))
            0: disp_data = $urandom;
            1: dp        = 8'($urandom);
            2: digit_en  = 8'($urandom);
            3: disp_en   = ($urandom_range(0, 3) != 0);
            default: ;
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_dp();
      test_no_tear();
      test_blank();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
